// File: rtl/rank_log_pkg.sv
// rank_log_pkg
//   Shared definitions for the rank change logger slice.
//   - Default widths/depth used as parameter defaults by the logger.
//   - Default log entry layout {value, stamp}.
//   - Pointer and level widths for the default depth.
package rank_log_pkg;

    localparam int unsigned RANK_DATA_W  = 32;
    localparam int unsigned RANK_STAMP_W = 16;
    localparam int unsigned RANK_DEPTH   = 8;
    localparam int unsigned RANK_DROP_W  = 8;

    localparam int unsigned PTR_W = $clog2(RANK_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    // Log entry at default widths. The logger declares an equivalent
    // local type sized from its own parameters.
    typedef struct packed {
        logic [RANK_DATA_W-1:0]  value;
        logic [RANK_STAMP_W-1:0] stamp;
    } rank_entry_t;

endpackage : rank_log_pkg

// File: rtl/rank_change_logger_fifo.sv
// sync_fifo_fwft
//   Single-clock first-word-fall-through FIFO, generic over the entry type.
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     push, din    write request and data; accepted when not full, or when
//                  full and a pop happens in the same cycle
//     pop          read request; ignored while empty
//     dout         head entry, all zeros while empty
//     full, empty  occupancy flags
//     level        registered occupancy, 0..DEPTH
module sync_fifo_fwft #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits coincide.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    T               mem [DEPTH];

    logic do_push;
    logic do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        do_pop  = pop && !empty;
        // When full, the slot being written is the head being popped this
        // same edge, so a simultaneous push is safe.
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule : sync_fifo_fwft

// File: rtl/rank_change_logger.sv
// rank_change_logger
//   Logs every change of the tracker's rank output as a {value, timestamp}
//   entry in a FWFT FIFO drained over valid/ready. Events lost to a full
//   FIFO set a sticky overflow flag and bump a saturating drop counter.
//   Ports:
//     clk, reset       rising-edge clock, synchronous active-high reset
//     rank_val         tracker output, sampled every cycle
//     clear_ovf        pulse; clears overflow and drop_count
//     out_valid/ready  head entry handshake
//     out_value/stamp  head entry fields, zero while empty
//     level            FIFO occupancy
//     overflow         sticky lost-event flag
//     drop_count       saturating lost-event count
module rank_change_logger
    import rank_log_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = RANK_DATA_W,
    parameter int unsigned STAMP_WIDTH = RANK_STAMP_W,
    parameter int unsigned DEPTH       = RANK_DEPTH,
    parameter int unsigned DROP_WIDTH  = RANK_DROP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  rank_val,
    input  logic                   clear_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_value,
    output logic [STAMP_WIDTH-1:0] out_stamp,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_WIDTH-1:0]  drop_count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  value;
        logic [STAMP_WIDTH-1:0] stamp;
    } entry_t;

    logic [DATA_WIDTH-1:0]  prev_val;
    logic [STAMP_WIDTH-1:0] stamp;

    logic   change;
    logic   pop;
    logic   accept;
    logic   drop;
    logic   fifo_full;
    logic   fifo_empty;
    entry_t din;
    entry_t dout;

    always_comb begin
        change    = (rank_val != prev_val);
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        accept    = change && (!fifo_full || pop);
        drop      = change && fifo_full && !pop;
        din.value = rank_val;
        din.stamp = stamp;
        out_value = dout.value;
        out_stamp = dout.stamp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_val <= '0;
            stamp    <= '0;
        end else begin
            prev_val <= rank_val;
            stamp    <= stamp + 1'b1;
        end
    end

    // A drop in the same cycle as clear_ovf takes precedence: the fresh
    // loss is reported as the first one after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
                drop_count <= DROP_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    sync_fifo_fwft #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule : rank_change_logger

// File: tb/tb_rank_change_logger.sv
module tb_rank_change_logger;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        reset_a = 1'b1;
    logic [31:0] rank_a  = '0;
    logic        clr_a   = 1'b0;
    logic        ready_a = 1'b0;
    logic        valid_a;
    logic [31:0] value_a;
    logic [15:0] stamp_a;
    logic [3:0]  level_a;
    logic        ovf_a;
    logic [7:0]  drop_a;

    // DUT B: 4-bit timestamp for wrap checks
    logic        reset_b = 1'b1;
    logic [31:0] rank_b  = '0;
    logic        clr_b   = 1'b0;
    logic        ready_b = 1'b0;
    logic        valid_b;
    logic [31:0] value_b;
    logic [3:0]  stamp_b;
    logic [3:0]  level_b;
    logic        ovf_b;
    logic [7:0]  drop_b;

    int checks = 0;
    int errors = 0;

    rank_change_logger dut_a (
        .clk(clk), .reset(reset_a), .rank_val(rank_a), .clear_ovf(clr_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_value(value_a),
        .out_stamp(stamp_a), .level(level_a), .overflow(ovf_a),
        .drop_count(drop_a)
    );

    rank_change_logger #(.STAMP_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset_b), .rank_val(rank_b), .clear_ovf(clr_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_value(value_b),
        .out_stamp(stamp_b), .level(level_b), .overflow(ovf_b),
        .drop_count(drop_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after an edge; the next edge is cycle 0 (stamp 0).
    task automatic reset_dut_a();
        reset_a = 1'b1;
        rank_a  = '0;
        clr_a   = 1'b0;
        tick();
        tick();
        reset_a = 1'b0;
    endtask

    logic [31:0] exp_seq [8];

    initial begin
        // ---- 1: idle after reset, ready high while empty ----
        ready_a = 1'b1;
        reset_dut_a();
        check("rst_valid", valid_a, 0);
        check("rst_level", level_a, 0);
        check("rst_value", value_a, 0);
        check("rst_stamp", stamp_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_drop", drop_a, 0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_valid", valid_a, 0);
        end
        check("idle_level", level_a, 0);
        check("idle_ovf", ovf_a, 0);

        // ---- 2: two changes, one-cycle latency ----
        ready_a = 1'b1;
        reset_dut_a();
        for (int c = 0; c <= 10; c++) begin
            rank_a = (c >= 7) ? 32'd9 : (c >= 3) ? 32'd5 : 32'd0;
            tick();
            if (c == 2) check("t2_pre_valid", valid_a, 0);
            if (c == 3) begin
                check("t2_e1_valid", valid_a, 1);
                check("t2_e1_value", value_a, 5);
                check("t2_e1_stamp", stamp_a, 3);
            end
            if (c == 4) check("t2_popped", valid_a, 0);
            if (c == 7) begin
                check("t2_e2_valid", valid_a, 1);
                check("t2_e2_value", value_a, 9);
                check("t2_e2_stamp", stamp_a, 7);
            end
            if (c == 8) check("t2_end_valid", valid_a, 0);
        end

        // ---- 3: ten changes into eight slots ----
        ready_a = 1'b0;
        reset_dut_a();
        for (int c = 0; c < 10; c++) begin
            rank_a = 32'(c + 1);
            tick();
        end
        check("t3_level", level_a, 8);
        check("t3_ovf", ovf_a, 1);
        check("t3_drop", drop_a, 2);
        ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_valid", valid_a, 1);
            check("t3_drain_value", value_a, 64'(i + 1));
            check("t3_drain_stamp", stamp_a, 64'(i));
            tick();
        end
        check("t3_empty_valid", valid_a, 0);
        check("t3_empty_level", level_a, 0);

        // ---- 4: push and pop on a full FIFO ----
        ready_a = 1'b0;
        reset_dut_a();
        for (int c = 0; c < 8; c++) begin
            rank_a = 32'(c + 1);
            tick();
        end
        check("t4_full_level", level_a, 8);
        rank_a  = 32'd20;
        ready_a = 1'b1;
        tick();
        check("t4_level", level_a, 8);
        check("t4_drop", drop_a, 0);
        check("t4_ovf", ovf_a, 0);
        exp_seq = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd20};
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_value", value_a, exp_seq[i]);
            if (i == 7) check("t4_last_stamp", stamp_a, 8);
            tick();
        end
        check("t4_empty", valid_a, 0);

        // ---- 5: clear racing a drop, clear alone, saturation ----
        ready_a = 1'b0;
        reset_dut_a();
        for (int c = 0; c < 10; c++) begin
            rank_a = 32'(c + 1);
            tick();
        end
        check("t5_pre_drop", drop_a, 2);
        rank_a = 32'd11;
        clr_a  = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t5_race_ovf", ovf_a, 1);
        check("t5_race_drop", drop_a, 1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t5_clr_ovf", ovf_a, 0);
        check("t5_clr_drop", drop_a, 0);
        for (int k = 0; k < 260; k++) begin
            rank_a = 32'(100 + k);
            tick();
        end
        check("t5_sat_drop", drop_a, 255);
        check("t5_sat_ovf", ovf_a, 1);
        check("t5_sat_level", level_a, 8);

        // ---- 6: 4-bit stamp wrap, reset with entries queued ----
        ready_b = 1'b0;
        rank_b  = '0;
        reset_b = 1'b1;
        tick();
        tick();
        reset_b = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            rank_b = (c >= 17) ? 32'd3 : 32'd0;
            tick();
        end
        check("t6_valid", valid_b, 1);
        check("t6_value", value_b, 3);
        check("t6_stamp_wrap", stamp_b, 1);
        rank_b = 32'd4;
        tick();
        rank_b = 32'd5;
        tick();
        check("t6_level3", level_b, 3);
        reset_b = 1'b1;
        tick();
        check("t6_rst_valid", valid_b, 0);
        check("t6_rst_level", level_b, 0);
        check("t6_rst_value", value_b, 0);
        check("t6_rst_stamp", stamp_b, 0);
        check("t6_rst_ovf", ovf_b, 0);
        reset_b = 1'b0;
        tick();
        check("t6_restart_valid", valid_b, 1);
        check("t6_restart_value", value_b, 5);
        check("t6_restart_stamp", stamp_b, 0);
        check("t6_drop", drop_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rank_change_logger
